pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port `clk`: input, 1 bit; single clock, all state updates on its rising edge.
REQ-002 SHALL have port `reset`: input, 1 bit; synchronous, active-low.
REQ-003 SHALL have port `en`: input, 1 bit; instruction-cycle strobe; no state change when 0.
REQ-004 SHALL have port `jump`: input, 1 bit; GOTO request.
REQ-005 SHALL have port `call`: input, 1 bit; CALL request (push, then jump).
REQ-006 SHALL have port `ret`: input, 1 bit; RETURN request (pop).
REQ-007 SHALL have port `skip`: input, 1 bit; conditional-skip taken (from the zero/bit-test flag path).
REQ-008 SHALL have port `target`: input, 11 bits; jump/call destination, low bits of the new PC.
REQ-009 SHALL have port `pch`: input, 2 bits; page bits, supply PC[12:11] on jump/call.
REQ-010 SHALL have port `pc`: output, 13 bits; current fetch address to instruction memory.
REQ-011 SHALL have port `flush`: output, 1 bit; the instruction fetched this cycle is to be discarded (NOP).
REQ-012 SHALL have port `depth`: output, 4 bits; number of valid stack entries, 0..8.
REQ-013 SHALL have port `stack_ovf`: output, 1 bit; sticky overflow flag.
REQ-014 SHALL have port `stack_unf`: output, 1 bit; sticky underflow flag.

Function
REQ-015 All updates SHALL occur only on a rising `clk` edge with `reset`=1 and `en`=1; with `en`=0 every register SHALL hold.
REQ-016 Request priority per enabled cycle SHALL be: `ret` > `call` > `jump` > `skip` > increment; lower-priority requests asserted in the same cycle SHALL be ignored.
REQ-017 Increment SHALL set pc <= pc+1 mod 2^13 (0x1FFF wraps to 0x0000).
REQ-018 `skip` SHALL set pc <= pc+1 mod 2^13 and set `flush`=1 for the next enabled cycle.
REQ-019 `jump` SHALL set pc <= {pch, target} and set `flush`=1 for the next enabled cycle.
REQ-020 `call` SHALL write (pc+1 mod 2^13) into stack[sp], advance sp <= sp+1 mod 8, set pc <= {pch, target}, and set `flush`=1.
REQ-021 `ret` SHALL set pc <= stack[sp-1 mod 8], set sp <= sp-1 mod 8, and set `flush`=1.
REQ-022 Stack: 8 entries x 13 bits, circular, sp 3 bits pointing to the next free slot.
REQ-023 `depth` SHALL increment on `call` saturating at 8 and decrement on `ret` saturating at 0.
REQ-024 A `call` at `depth`=8 SHALL overwrite the oldest entry, keep `depth`=8, and set `stack_ovf`.
REQ-025 A `ret` at `depth`=0 SHALL still pop stack[sp-1] and move sp, keep `depth`=0, and set `stack_unf`.
REQ-026 `stack_ovf`/`stack_unf` SHALL be sticky and clear only on reset.
REQ-027 While `flush`=1 and `en`=1, `jump`/`call`/`ret`/`skip` SHALL be ignored, pc SHALL increment, and `flush` SHALL clear (one-cycle squash).
REQ-028 Back-to-back transfers SHALL therefore take effect no more often than every second enabled cycle.
REQ-029 `flush` SHALL be a registered output; `pc` SHALL be a registered output with no combinational path from inputs.

Reset
REQ-030 With `reset`=0 at a rising edge, the following SHALL take the value 0 regardless of `en` or requests: `pc`, `sp`, `depth`, `flush`, `stack_ovf`, `stack_unf`, and all 8 stack entries.
REQ-031 Reset asserted mid-call/return SHALL discard the operation; the first enabled cycle after release SHALL fetch 0x0000 with `flush`=0.

Verification
REQ-032 Scenario: release reset, 3 enabled cycles with no requests -> pc = 0x0000, 0x0001, 0x0002, 0x0003; `flush`=0 throughout.
REQ-033 Scenario: pc=0x0010, `jump`, pch=2'b01, target=0x055 -> next pc=0x0855 with `flush`=1; next cycle pc=0x0856 with `flush`=0.
REQ-034 Scenario: pc=0x0020, `call` target=0x100, pch=0; later `ret` -> pc=0x0100 with depth=1, then pc=0x0021 with depth=0; `flush` pulses after each transfer.
REQ-035 Scenario: 9 calls (each followed by its flush cycle) -> depth=8, stack_ovf=1; 8 returns pop return addresses of calls 9..2; a 9th `ret` -> stack_unf=1, depth=0.
REQ-036 Scenario: `ret`+`call`+`jump` asserted together -> only pop occurs; assert `jump` in the flush cycle -> ignored, pc increments.
REQ-037 Scenario: pc=0x1FFF with increment -> 0x0000; `en`=0 for 4 cycles -> all outputs hold; `reset`=0 while `flush`=1 -> pc=0, flush=0 at that edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer -- program counter with an 8-deep circular return stack.
//
// Each enabled cycle the PC either increments, skips, jumps, calls or
// returns (priority ret > call > jump > skip > increment). Every transfer
// and every skip raises a one-cycle flush that squashes the instruction
// fetched next. During that squash cycle all requests are ignored.
//
// Ports
//   clk       in   clock, rising edge active
//   reset     in   synchronous active-low reset
//   en        in   instruction-cycle strobe; all state holds when 0
//   jump      in   GOTO request
//   call      in   CALL request (push return address, then jump)
//   ret       in   RETURN request (pop)
//   skip      in   conditional skip taken
//   target    in   [10:0] jump/call destination, PC[10:0]
//   pch       in   [1:0]  page bits, PC[12:11] on jump/call
//   pc        out  [12:0] current fetch address (registered)
//   flush     out  discard the instruction fetched this cycle (registered)
//   depth     out  [3:0]  valid stack entries, 0..8
//   stack_ovf out  sticky overflow flag
//   stack_unf out  sticky underflow flag
// ---------------------------------------------------------------------------
module pc_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        jump,
   input  logic        call,
   input  logic        ret,
   input  logic        skip,
   input  logic [10:0] target,
   input  logic [1:0]  pch,
   output logic [12:0] pc,
   output logic        flush,
   output logic [3:0]  depth,
   output logic        stack_ovf,
   output logic        stack_unf
);

   localparam int unsigned PC_W    = 13;
   localparam int unsigned STK_D   = 8;
   localparam int unsigned SP_W    = 3;
   localparam int unsigned DEPTH_W = 4;

   logic [PC_W-1:0]    pc_q, pc_d;
   logic               flush_q, flush_d;
   logic [SP_W-1:0]    sp_q, sp_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic [PC_W-1:0]    stack_q [STK_D];

   logic [PC_W-1:0]    pc_inc;
   logic [PC_W-1:0]    pc_jmp;
   logic [SP_W-1:0]    sp_dec;
   logic               push_we;

   assign pc_inc = pc_q + PC_W'(1);
   assign pc_jmp = {pch, target};
   assign sp_dec = sp_q - SP_W'(1);

   // Next-state selection; a pending flush overrides every request.
   always_comb begin
      pc_d    = pc_q;
      flush_d = flush_q;
      sp_d    = sp_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_we = 1'b0;
      if (flush_q) begin
         pc_d    = pc_inc;
         flush_d = 1'b0;
      end else if (ret) begin
         pc_d    = stack_q[sp_dec];
         sp_d    = sp_dec;
         flush_d = 1'b1;
         if (depth_q == DEPTH_W'(0)) begin
            unf_d = 1'b1;
         end else begin
            depth_d = depth_q - DEPTH_W'(1);
         end
      end else if (call) begin
         push_we = 1'b1;
         pc_d    = pc_jmp;
         sp_d    = sp_q + SP_W'(1);
         flush_d = 1'b1;
         // Full stack: the push overwrites the oldest entry.
         if (depth_q == DEPTH_W'(STK_D)) begin
            ovf_d = 1'b1;
         end else begin
            depth_d = depth_q + DEPTH_W'(1);
         end
      end else if (jump) begin
         pc_d    = pc_jmp;
         flush_d = 1'b1;
      end else if (skip) begin
         pc_d    = pc_inc;
         flush_d = 1'b1;
      end else begin
         pc_d = pc_inc;
      end
   end

   // State registers; reset wins over en.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q    <= '0;
         flush_q <= 1'b0;
         sp_q    <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < STK_D; i++) begin
            stack_q[i] <= '0;
         end
      end else if (en) begin
         pc_q    <= pc_d;
         flush_q <= flush_d;
         sp_q    <= sp_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         if (push_we) begin
            stack_q[sp_q] <= pc_inc;
         end
      end
   end

   assign pc        = pc_q;
   assign flush     = flush_q;
   assign depth     = depth_q;
   assign stack_ovf = ovf_q;
   assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer -- self-checking bench for pc_sequencer. A behavioural
// model (integers, modulo arithmetic, an 8-slot array) tracks the expected
// PC, flush, depth and sticky flags; scenario tasks compare against it and
// against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        jump;
   logic        call;
   logic        ret;
   logic        skip;
   logic [10:0] target;
   logic [1:0]  pch;
   logic [12:0] pc;
   logic        flush;
   logic [3:0]  depth;
   logic        stack_ovf;
   logic        stack_unf;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_pc;
   bit m_flush;
   int m_stack [8];
   int m_sp;
   int m_depth;
   bit m_ovf;
   bit m_unf;

   pc_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .jump      (jump),
      .call      (call),
      .ret       (ret),
      .skip      (skip),
      .target    (target),
      .pch       (pch),
      .pc        (pc),
      .flush     (flush),
      .depth     (depth),
      .stack_ovf (stack_ovf),
      .stack_unf (stack_unf)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] exp_vec();
      return {13'(m_pc), m_flush, 4'(m_depth), m_ovf, m_unf};
   endfunction

   function automatic logic [19:0] dut_vec();
      return {pc, flush, depth, stack_ovf, stack_unf};
   endfunction

   // Behavioural model of one rising edge.
   task automatic model_edge(input bit rst_n, input bit e, input bit j, input bit c,
                             input bit r, input bit s, input int t, input int p);
      if (!rst_n) begin
         m_pc = 0; m_flush = 0; m_sp = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
         for (int i = 0; i < 8; i++) m_stack[i] = 0;
      end else if (e) begin
         if (m_flush) begin
            m_pc = (m_pc + 1) % 8192;
            m_flush = 0;
         end else if (r) begin
            m_sp = (m_sp + 7) % 8;
            m_pc = m_stack[m_sp];
            if (m_depth == 0) m_unf = 1; else m_depth = m_depth - 1;
            m_flush = 1;
         end else if (c) begin
            m_stack[m_sp] = (m_pc + 1) % 8192;
            m_sp = (m_sp + 1) % 8;
            if (m_depth == 8) m_ovf = 1; else m_depth = m_depth + 1;
            m_pc = p * 2048 + t;
            m_flush = 1;
         end else if (j) begin
            m_pc = p * 2048 + t;
            m_flush = 1;
         end else begin
            m_pc = (m_pc + 1) % 8192;
            m_flush = s;
         end
      end
   endtask

   // Drive one cycle, advance the model, sample 1 time unit after the edge.
   task automatic cyc(input bit rst_n, input bit e, input bit j, input bit c,
                      input bit r, input bit s, input int t, input int p);
      reset = rst_n; en = e; jump = j; call = c; ret = r; skip = s;
      target = 11'(t); pch = 2'(p);
      @(posedge clk);
      model_edge(rst_n, e, j, c, r, s, t, p);
      #1;
   endtask

   task automatic idle();
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      // Reset with random requests and enable still clears everything.
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)));
         n_checks++;
         if (dut_vec() !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state got=%h expected=00000", dut_vec());
         end
      end
   endtask

   task automatic test_increment();
      do_reset();
      n_checks++;
      if (pc !== 13'h0000 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL inc_start pc=%h flush=%b expected pc=0000 flush=0", pc, flush);
      end
      for (int i = 1; i <= 3; i++) begin
         idle();
         n_checks++;
         if (pc !== 13'(i) || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_step%0d pc=%h flush=%b expected pc=%h flush=0", i, pc, flush, 13'(i));
         end
      end
   endtask

   task automatic test_jump();
      do_reset();
      repeat (16) idle();
      cyc(1, 1, 1, 0, 0, 0, 'h055, 1);
      n_checks++;
      if (pc !== 13'h0855 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL jump_target pc=%h flush=%b expected pc=0855 flush=1", pc, flush);
      end
      idle();
      n_checks++;
      if (pc !== 13'h0856 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL jump_after pc=%h flush=%b expected pc=0856 flush=0", pc, flush);
      end
      // Skip: increment plus one flushed slot.
      cyc(1, 1, 0, 0, 0, 1, 0, 0);
      n_checks++;
      if (pc !== 13'h0857 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL skip pc=%h flush=%b expected pc=0857 flush=1", pc, flush);
      end
      idle();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL skip_after got=%h expected=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_call_ret();
      do_reset();
      repeat (32) idle();
      cyc(1, 1, 0, 1, 0, 0, 'h100, 0);
      n_checks++;
      if (pc !== 13'h0100 || depth !== 4'd1 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL call pc=%h depth=%0d flush=%b expected pc=0100 depth=1 flush=1", pc, depth, flush);
      end
      idle();
      repeat (3) idle();
      cyc(1, 1, 0, 0, 1, 0, 0, 0);
      n_checks++;
      if (pc !== 13'h0021 || depth !== 4'd0 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL ret pc=%h depth=%0d flush=%b expected pc=0021 depth=0 flush=1", pc, depth, flush);
      end
      idle();
      n_checks++;
      if (pc !== 13'h0022 || flush !== 1'b0 || stack_unf !== 1'b0) begin
         n_fail++;
         $display("FAIL ret_after pc=%h flush=%b unf=%b expected pc=0022 flush=0 unf=0", pc, flush, stack_unf);
      end
   endtask

   task automatic test_overflow();
      int ret_addr [9];
      do_reset();
      for (int k = 0; k < 9; k++) begin
         ret_addr[k] = (m_pc + 1) % 8192;
         cyc(1, 1, 0, 1, 0, 0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)));
         idle();
      end
      n_checks++;
      if (depth !== 4'd8 || stack_ovf !== 1'b1 || stack_unf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf depth=%0d ovf=%b unf=%b expected depth=8 ovf=1 unf=0", depth, stack_ovf, stack_unf);
      end
      // Returns pop calls 9 down to 2; call 1 was overwritten.
      for (int k = 8; k >= 1; k--) begin
         cyc(1, 1, 0, 0, 1, 0, 0, 0);
         n_checks++;
         if (pc !== 13'(ret_addr[k]) || depth !== 4'(k - 1)) begin
            n_fail++;
            $display("FAIL pop_call%0d pc=%h depth=%0d expected pc=%h depth=%0d",
                     k + 1, pc, depth, 13'(ret_addr[k]), k - 1);
         end
         idle();
      end
      cyc(1, 1, 0, 0, 1, 0, 0, 0);
      n_checks++;
      if (stack_unf !== 1'b1 || depth !== 4'd0 || stack_ovf !== 1'b1 || pc !== 13'(ret_addr[8])) begin
         n_fail++;
         $display("FAIL unf pc=%h depth=%0d ovf=%b unf=%b expected pc=%h depth=0 ovf=1 unf=1",
                  pc, depth, stack_ovf, stack_unf, 13'(ret_addr[8]));
      end
      idle();
   endtask

   task automatic test_priority();
      do_reset();
      repeat (5) idle();
      cyc(1, 1, 0, 1, 0, 0, 'h300, 0);       // push 0x0006, pc=0x0300
      idle();                                // 0x0301
      cyc(1, 1, 1, 1, 1, 1, 'h7AA, 3);       // only the pop happens
      n_checks++;
      if (pc !== 13'h0006 || depth !== 4'd0 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_pop pc=%h depth=%0d flush=%b expected pc=0006 depth=0 flush=1", pc, depth, flush);
      end
      cyc(1, 1, 1, 0, 0, 0, 'h123, 2);       // jump in flush cycle is ignored
      n_checks++;
      if (pc !== 13'h0007 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_flush_jump pc=%h flush=%b expected pc=0007 flush=0", pc, flush);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 1, 0, 0, 0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)));
         n_checks++;
         if (dut_vec() !== exp_vec() || flush !== 1'(~i & 1)) begin
            n_fail++;
            $display("FAIL b2b_jump%0d got=%h expected=%h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_wrap_hold_reset();
      logic [19:0] held;
      do_reset();
      cyc(1, 1, 1, 0, 0, 0, 'h7FF, 3);
      idle();
      n_checks++;
      if (pc !== 13'h0000 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap pc=%h flush=%b expected pc=0000 flush=0", pc, flush);
      end
      cyc(1, 1, 0, 1, 0, 0, 'h040, 1);       // call, leaves flush=1
      held = dut_vec();
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)));
         n_checks++;
         if (dut_vec() !== 20'h08411 >> 0 && dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL hold%0d got=%h expected=%h", i, dut_vec(), exp_vec());
         end else if (dut_vec() !== held) begin
            n_fail++;
            $display("FAIL hold%0d got=%h expected=%h", i, dut_vec(), held);
         end
      end
      cyc(0, 1, 0, 1, 0, 0, 'h111, 1);       // reset while flush=1 and call asserted
      n_checks++;
      if (pc !== 13'h0000 || flush !== 1'b0 || depth !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_mid pc=%h flush=%b depth=%0d expected pc=0000 flush=0 depth=0", pc, flush, depth);
      end
      idle();
      n_checks++;
      if (pc !== 13'h0001 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset pc=%h flush=%b expected pc=0001 flush=0", pc, flush);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
             int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)));
         n_checks++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random%0d got=%h expected=%h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; skip = 1'b0;
      target = '0; pch = '0;
      test_reset();
      test_increment();
      test_jump();
      test_call_ret();
      test_overflow();
      test_priority();
      test_back_to_back();
      test_wrap_hold_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
